// File: rtl/rfdc_capture.sv
// RF ADC snapshot capture: arm, wait for a trigger beat, store DEPTH consecutive
// valid beats into a simple dual-port buffer, then hold the buffer for readback.
module rfdc_capture #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 64,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  trig,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  busy,
  output logic                  done,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [15:0]           gap_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t                r_state;
  logic [AW-1:0]         r_wr_ptr;
  logic [15:0]           r_gap;
  logic                  r_tready;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic          w_beat;
  logic          w_we;
  logic [AW-1:0] w_waddr;

  assign w_beat  = s_axis_tvalid & r_tready;
  assign w_we    = ((r_state == S_ARMED) && trig && w_beat) ||
                   ((r_state == S_CAPTURE) && w_beat);
  // The trigger beat always lands at index 0 regardless of the stale pointer.
  assign w_waddr = (r_state == S_ARMED) ? '0 : r_wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_gap    <= '0;
      r_tready <= 1'b0;
    end else begin
      r_tready <= 1'b1;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            r_state  <= S_ARMED;
            r_wr_ptr <= '0;
            r_gap    <= '0;
          end
        end
        S_ARMED: begin
          if (trig && w_beat) begin
            r_state  <= S_CAPTURE;
            r_wr_ptr <= AW'(1);
          end
        end
        S_CAPTURE: begin
          if (w_beat) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (r_wr_ptr == AW'(DEPTH - 1)) r_state <= S_DONE;
          end else if (r_gap != '1) begin
            r_gap <= r_gap + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= s_axis_tdata;
  end

  // Registered read port; a same-cycle write to the same index returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= r_mem[rd_addr];
    end
  end

  assign s_axis_tready = r_tready;
  assign busy          = (r_state == S_ARMED) || (r_state == S_CAPTURE);
  assign done          = (r_state == S_DONE);
  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign gap_cnt       = r_gap;

endmodule

// File: doc/rfdc_capture.md
RFDC_CAPTURE -- requirements
Module: rfdc_capture

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 256, the AXI4-Stream beat width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, the capture buffer depth in beats (power of two, >=2).
REQ-003 Port clk, input, 1: the single clock for all logic.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port arm, input, 1: one-cycle request to arm a new capture.
REQ-006 Port trig, input, 1: capture start qualifier, sampled only while armed.
REQ-007 Port s_axis_tdata, input, DATA_WIDTH: ADC stream beat.
REQ-008 Port s_axis_tvalid, input, 1: beat valid.
REQ-009 Port s_axis_tready, output, 1: sink ready.
REQ-010 Port busy, output, 1: high in ARMED or CAPTURE.
REQ-011 Port done, output, 1: high in DONE.
REQ-012 Port rd_en, input, 1: readback request.
REQ-013 Port rd_addr, input, $clog2(DEPTH): readback beat index.
REQ-014 Port rd_data, output, DATA_WIDTH: readback beat.
REQ-015 Port rd_valid, output, 1: rd_data valid strobe.
REQ-016 Port gap_cnt, output, 16: count of CAPTURE cycles with s_axis_tvalid low.

Function
REQ-017 The state machine SHALL have states IDLE, ARMED, CAPTURE, DONE, registered on clk.
REQ-018 s_axis_tready SHALL be 1 in every state out of reset (the ADC stream is never stalled); beats outside CAPTURE and outside the triggering beat SHALL be discarded.
REQ-019 IDLE or DONE with arm=1 -> ARMED next cycle; wr_ptr, gap_cnt cleared to 0.
REQ-020 arm in ARMED or CAPTURE SHALL be ignored.
REQ-021 ARMED with trig=1 and s_axis_tvalid=1 in the same cycle: that beat SHALL be written to buffer[0], wr_ptr -> 1, state -> CAPTURE.
REQ-022 ARMED with trig=1 and s_axis_tvalid=0: no transition; trig is not latched.
REQ-023 CAPTURE: each cycle with s_axis_tvalid=1 SHALL write the beat to buffer[wr_ptr] and increment wr_ptr.
REQ-024 CAPTURE: each cycle with s_axis_tvalid=0 SHALL increment gap_cnt, saturating at 16'hFFFF.
REQ-025 When the beat written is at index DEPTH-1, state SHALL go to DONE the next cycle; wr_ptr SHALL not wrap into index 0 in the same capture.
REQ-026 DEPTH SHALL be exactly DEPTH beats captured per arm; buffer[i] holds the i-th valid beat after trigger, including the trigger beat.
REQ-027 Readback: rd_en=1 at cycle N SHALL drive rd_data=buffer[rd_addr] and rd_valid=1 at cycle N+1 (latency 1); rd_valid=0 otherwise.
REQ-028 Readback SHALL be accepted in any state; during CAPTURE unwritten locations return prior contents.
REQ-029 Simultaneous write and read of the same index SHALL return the old contents (read-before-write).
REQ-030 busy and done SHALL be decoded directly from the state register, glitch-free, with no extra latency.
REQ-031 Buffer SHALL be inferable as simple dual-port block RAM (one write port, one registered read port).

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, wr_ptr 0, gap_cnt 0, busy 0, done 0, rd_valid 0, s_axis_tready 0.
REQ-033 rd_data SHALL be 0 after reset until the first read; buffer contents SHALL not be cleared by reset.
REQ-034 Reset mid-CAPTURE SHALL abort the capture; after release the block sits in IDLE until arm.
REQ-035 s_axis_tready SHALL rise on the first clk edge after rst_n deasserts.

Verification
REQ-036 Reset, arm, trig=1 with continuous tvalid carrying beat value k at beat k -> busy for 64 beats, done=1, gap_cnt=0, reading addr 0..63 returns 0..63 with 1-cycle latency.
REQ-037 Arm, trig held 0 for 100 valid beats then 1 on beat value 500 -> buffer[0]=500, buffer[63]=563.
REQ-038 During CAPTURE deassert tvalid every 4th cycle -> still 64 beats stored in order, gap_cnt equals number of idle cycles, done only after 64th valid beat.
REQ-039 Pulse arm in CAPTURE and in ARMED -> no effect; arm in DONE -> ARMED, gap_cnt=0, done=0 next cycle.
REQ-040 Assert rst_n low after beat 20 of a capture -> state IDLE, busy=0, done=0, tready=0 immediately; buffer[0..19] still readable after release.
REQ-041 Same-cycle write of beat 7 and read of addr 7 during CAPTURE -> rd_data shows previous buffer[7]; next read shows new value.
